bubble_host_reader: RTL and testbench
=====================================

Name: bubble_host_reader

Overview:
- Host-side counterpart of the bubble interface served by the emulator core.
- Drives nBSS, nBSEN, nREPEN, nBOOTEN and nSWAPEN toward the emulator, samples DOUT0-3 on the emulator's 4 MHz CLKOUT, and assembles one page into a byte stream.
- Used on the USB/bench side to read back and check emulated pages.
- Sits beside the FIFO/USB logic and is clocked by MCLK (48 MHz).

Parameters:
- BSS_CYC, 4: bubble-clock rising edges with nBSS low before the replicate phase.
- REP_CYC, 2: bubble-clock rising edges with nREPEN low.
- BYTES_PER_PAGE, 64: bytes captured per read command.
- TIMEOUT_MCLK, 96: MCLK cycles with no bubble-clock rising edge before abort (2 ms-class margins are handled by firmware).

Ports:
- MCLK  in  1  48 MHz system clock
- nRESET  in  1  asynchronous active-low reset
- START  in  1  one-cycle read request; ignored unless idle
- BOOTMODE  in  1  1 = boot loop read (nBOOTEN asserted), 0 = user page
- BITWIDTH4  in  1  1 = 4 data lanes, 0 = 2 lanes (DOUT0, DOUT1)
- BCLKIN  in  1  emulator CLKOUT, asynchronous
- DIN  in  4  emulator DOUT3..DOUT0, asynchronous
- nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN  out  1 each  bubble control, active low
- BYTE  out  8  assembled byte
- BYTE_VALID  out  1  one-cycle pulse, BYTE valid
- BUSY  out  1  high from the cycle after an accepted START until return to IDLE
- DONE  out  1  one-cycle pulse after the last byte
- TIMEOUT  out  1  one-cycle pulse on abort

Behaviour:
- Reset (async, nRESET low): all n* outputs 1; BYTE 0; BYTE_VALID, BUSY, DONE, TIMEOUT 0; state IDLE; counters 0.
- Synchronisation:
  - BCLKIN and DIN pass through a 2-flop synchroniser.
  - Edge `bedge` = sync1 & ~sync2_d.
  - DIN is sampled from the same pipeline stage, so data and edge stay aligned.
  - Latency from a BCLKIN pin rise to `bedge` is 3 MCLK cycles.
- FSM states:
  - IDLE: outputs inactive. START=1 latches BOOTMODE and BITWIDTH4 and goes to BSS.
  - BSS: nBSS=0; count `bedge` to BSS_CYC; then go to REP.
  - REP: nBSS=0, nREPEN=0, nBOOTEN=~boot_l; count `bedge` to REP_CYC; then go to SHIFT.
  - SHIFT: nBSS=0, nBSEN=0, nBOOTEN=~boot_l, nREPEN=1. On each `bedge`, shift in 2 or 4 bits: LSB first, lane0 is the lower bit within each sample. A full byte needs 4 edges in 2-lane mode and 2 edges in 4-lane mode.
  - DONE_S: DONE=1 for one cycle, all n* outputs = 1, then IDLE.
  - ERR: TIMEOUT=1 for one cycle, all n* outputs = 1, then IDLE.
- Byte output: registered BYTE_VALID is raised the MCLK cycle after the completing `bedge`. On the final byte (count = BYTES_PER_PAGE-1), SHIFT goes to DONE_S in the same cycle BYTE_VALID is raised.
- nSWAPEN is held 1 in all states (reserved).
- Timeout:
  - Watchdog reloads on every `bedge` and on entry to BSS.
  - In BSS, REP or SHIFT, reaching TIMEOUT_MCLK goes to ERR.
  - A partial byte is discarded with no BYTE_VALID.
- START while BUSY is ignored; it is not queued.
- BITWIDTH4 or BOOTMODE changes mid-read have no effect; the latched copies are used.
- Byte counter is 7 bits and must not wrap within a page. A `bedge` arriving in the DONE_S cycle is ignored.
- Reset mid-read: outputs return to reset values immediately, asynchronously.

Decomposition:
- Shared package bubble_host_pkg:
  - state encoding (IDLE, BSS, REP, SHIFT, DONE_S, ERR)
  - lane-count constants (2/4)
  - edges-per-byte constants (4/2)
- One sub-module, bubble_host_sync: 2-flop synchroniser plus edge detector for BCLKIN/DIN, outputs `bedge` and `din_s[3:0]`.

Test Plan:
- 2-lane read, BOOTMODE=0, DIN pattern 01,10,11,00 per 4 edges -> 64 BYTE_VALID pulses each with BYTE=0x39; nBOOTEN stays 1; DONE one cycle after the 64th byte.
- 4-lane read, BOOTMODE=1, DIN 0xA then 0x5 -> BYTE=0x5A ×64. nBOOTEN is low from REP through SHIFT. nBSS leads nBSEN by 4+2 bclk edges.
- BCLKIN stopped after 10 bytes -> TIMEOUT pulse 96 MCLK cycles after the last edge; no 11th byte; all n* outputs return to 1.
- START pulsed during SHIFT, and BITWIDTH4 toggled mid-read -> byte count and values unchanged from the undisturbed run.
- nRESET low during SHIFT -> nBSS, nBSEN and nBOOTEN go to 1 without waiting for MCLK; BUSY=0; the next START yields a full 64-byte read.
- nSWAPEN checked to be 1 throughout all of the above.

Source files
------------

// File: rtl/bubble_host_pkg.sv
// Shared types and constants for the host-side bubble page reader.
package bubble_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BSS,
    REP,
    SHIFT,
    DONE_S,
    ERR
  } hostState_e;

  localparam int LANES_2          = 2;
  localparam int LANES_4          = 4;
  localparam int EDGES_PER_BYTE_2 = 4;
  localparam int EDGES_PER_BYTE_4 = 2;

  localparam int CNT_W      = 3;
  localparam int BYTE_CNT_W = 7;
  localparam int WDOG_W     = 7;

  // Number of bubble-clock edges needed to fill one byte for the latched lane width.
  function automatic logic [CNT_W-1:0] edgesPerByte(input logic wide);
    return wide ? CNT_W'(EDGES_PER_BYTE_4) : CNT_W'(EDGES_PER_BYTE_2);
  endfunction

  // Bits arrive LSB first, so new lanes enter at the top and older ones drift down.
  function automatic logic [7:0] shiftIn(input logic [7:0] cur, input logic [3:0] din, input logic wide);
    return wide ? {din, cur[7:LANES_4]} : {din[1:0], cur[7:LANES_2]};
  endfunction

endpackage

// File: rtl/bubble_host_sync.sv
// Brings the emulator's CLKOUT and data lanes into the MCLK domain and flags
// each rising bubble-clock edge together with the data seen at that edge.
module bubble_host_sync
  import bubble_host_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       bclk_i,
  input  logic [3:0] din_i,
  output logic       bedge_o,
  output logic [3:0] dinSync_o
);

  logic       bclkMeta_q;
  logic       bclkSync_q;
  logic       bclkPrev_q;
  logic       bedge_q;
  logic [3:0] dinMeta_q;
  logic [3:0] dinSync_q;
  logic [3:0] dinOut_q;

  // Two-flop synchroniser; clock and data go through identical stages so they stay aligned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bclkMeta_q <= 1'b0;
      bclkSync_q <= 1'b0;
      dinMeta_q  <= '0;
      dinSync_q  <= '0;
    end else begin
      bclkMeta_q <= bclk_i;
      bclkSync_q <= bclkMeta_q;
      dinMeta_q  <= din_i;
      dinSync_q  <= dinMeta_q;
    end
  end

  // Registered rising-edge detect with the matching data sample captured alongside it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bclkPrev_q <= 1'b0;
      bedge_q    <= 1'b0;
      dinOut_q   <= '0;
    end else begin
      bclkPrev_q <= bclkSync_q;
      bedge_q    <= bclkSync_q & ~bclkPrev_q;
      dinOut_q   <= dinSync_q;
    end
  end

  assign bedge_o   = bedge_q;
  assign dinSync_o = dinOut_q;

endmodule

// File: rtl/bubble_host_reader.sv
// Host-side bubble page reader: sequences the bubble control strobes, shifts in
// the emulator's data lanes on each bubble-clock edge and emits a page of bytes.
module bubble_host_reader
  import bubble_host_pkg::*;
#(
  parameter int BSS_CYC        = 4,
  parameter int REP_CYC        = 2,
  parameter int BYTES_PER_PAGE = 64,
  parameter int TIMEOUT_MCLK   = 96
) (
  input  logic       MCLK,
  input  logic       nRESET,
  input  logic       START,
  input  logic       BOOTMODE,
  input  logic       BITWIDTH4,
  input  logic       BCLKIN,
  input  logic [3:0] DIN,
  output logic       nBSS,
  output logic       nBSEN,
  output logic       nREPEN,
  output logic       nBOOTEN,
  output logic       nSWAPEN,
  output logic [7:0] BYTE,
  output logic       BYTE_VALID,
  output logic       BUSY,
  output logic       DONE,
  output logic       TIMEOUT
);

  hostState_e            state_q;
  logic                  boot_q;
  logic                  wide_q;
  logic [CNT_W-1:0]      edgeCnt_q;
  logic [BYTE_CNT_W-1:0] byteCnt_q;
  logic [WDOG_W-1:0]     wdog_q;
  logic [7:0]            shift_q;
  logic [7:0]            byte_q;
  logic                  byteValid_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  timeout_q;
  logic                  nBss_q;
  logic                  nBsen_q;
  logic                  nRepen_q;
  logic                  nBooten_q;

  logic                  bedge;
  logic [3:0]            dinS;
  logic [7:0]            shift_d;
  logic                  active;
  logic                  wdogExpired;

  bubble_host_sync uSync (
    .clk_i     (MCLK),
    .rst_ni    (nRESET),
    .bclk_i    (BCLKIN),
    .din_i     (DIN),
    .bedge_o   (bedge),
    .dinSync_o (dinS)
  );

  assign shift_d     = shiftIn(shift_q, dinS, wide_q);
  assign active      = (state_q == BSS) || (state_q == REP) || (state_q == SHIFT);
  assign wdogExpired = (wdog_q == WDOG_W'(TIMEOUT_MCLK - 1));

  // Watchdog: restarts on every bubble-clock edge and is held clear outside an active read.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      wdog_q <= '0;
    end else if (active) begin
      wdog_q <= bedge ? '0 : wdog_q + 1'b1;
    end else begin
      wdog_q <= '0;
    end
  end

  // Read sequencer with registered strobes and one-cycle status pulses.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= IDLE;
      boot_q      <= 1'b0;
      wide_q      <= 1'b0;
      edgeCnt_q   <= '0;
      byteCnt_q   <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      byteValid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      nBss_q      <= 1'b1;
      nBsen_q     <= 1'b1;
      nRepen_q    <= 1'b1;
      nBooten_q   <= 1'b1;
    end else begin
      byteValid_q <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      if (active && !bedge && wdogExpired) begin
        state_q   <= ERR;
        nBss_q    <= 1'b1;
        nBsen_q   <= 1'b1;
        nRepen_q  <= 1'b1;
        nBooten_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (START) begin
              state_q   <= BSS;
              boot_q    <= BOOTMODE;
              wide_q    <= BITWIDTH4;
              edgeCnt_q <= '0;
              byteCnt_q <= '0;
              shift_q   <= '0;
              busy_q    <= 1'b1;
              nBss_q    <= 1'b0;
            end
          end
          BSS: begin
            if (bedge) begin
              if (edgeCnt_q == CNT_W'(BSS_CYC - 1)) begin
                state_q   <= REP;
                edgeCnt_q <= '0;
                nRepen_q  <= 1'b0;
                nBooten_q <= ~boot_q;
              end else begin
                edgeCnt_q <= edgeCnt_q + 1'b1;
              end
            end
          end
          REP: begin
            if (bedge) begin
              if (edgeCnt_q == CNT_W'(REP_CYC - 1)) begin
                state_q   <= SHIFT;
                edgeCnt_q <= '0;
                nRepen_q  <= 1'b1;
                nBsen_q   <= 1'b0;
              end else begin
                edgeCnt_q <= edgeCnt_q + 1'b1;
              end
            end
          end
          SHIFT: begin
            if (bedge) begin
              shift_q <= shift_d;
              if (edgeCnt_q == edgesPerByte(wide_q) - 1'b1) begin
                edgeCnt_q   <= '0;
                byte_q      <= shift_d;
                byteValid_q <= 1'b1;
                byteCnt_q   <= byteCnt_q + 1'b1;
                if (byteCnt_q == BYTE_CNT_W'(BYTES_PER_PAGE - 1)) begin
                  state_q   <= DONE_S;
                  nBss_q    <= 1'b1;
                  nBsen_q   <= 1'b1;
                  nRepen_q  <= 1'b1;
                  nBooten_q <= 1'b1;
                end
              end else begin
                edgeCnt_q <= edgeCnt_q + 1'b1;
              end
            end
          end
          DONE_S: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          ERR: begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign nBSS       = nBss_q;
  assign nBSEN      = nBsen_q;
  assign nREPEN     = nRepen_q;
  assign nBOOTEN    = nBooten_q;
  assign nSWAPEN    = 1'b1;
  assign BYTE       = byte_q;
  assign BYTE_VALID = byteValid_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign TIMEOUT    = timeout_q;

endmodule

// File: tb/tb_bubble_host_reader.sv
// Self-checking bench for bubble_host_reader: an emulator-like bubble clock
// feeds random lane data and a page-level model predicts the byte stream.
module tb_bubble_host_reader;

  localparam int MCLK_HALF = 10;
  localparam int BCLK_HALF = 120;
  localparam int PRE_EDGES = 6;
  localparam int PAGE      = 64;
  localparam int TO_MCLK   = 96;

  logic       MCLK      = 1'b0;
  logic       nRESET    = 1'b0;
  logic       START     = 1'b0;
  logic       BOOTMODE  = 1'b0;
  logic       BITWIDTH4 = 1'b0;
  logic       BCLKIN    = 1'b0;
  logic [3:0] DIN       = 4'h0;
  logic       nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN;
  logic [7:0] BYTE;
  logic       BYTE_VALID, BUSY, DONE, TIMEOUT;

  int checks = 0;
  int errors = 0;

  logic [3:0] sampleQ[$];
  int         edgeLimit = 0;
  int         edgesSent = 0;
  bit         bclkIdle  = 1'b1;
  time        lastRise  = 0;
  event       startBclk;

  int         cycle          = 0;
  logic [7:0] gotQ[$];
  int         doneCnt        = 0;
  int         toCnt          = 0;
  int         swapErr        = 0;
  int         bootErr        = 0;
  int         lastValidCycle = 0;
  int         doneCycle      = 0;
  time        toTime         = 0;
  int         repFalls       = 0;
  int         repFallEdge    = -1;
  int         bsenFalls      = 0;
  int         bsenFallEdge   = -1;
  logic       prevRep        = 1'b1;
  logic       prevBsen       = 1'b1;
  bit         curBoot        = 1'b0;

  bubble_host_reader dut (
    .MCLK       (MCLK),
    .nRESET     (nRESET),
    .START      (START),
    .BOOTMODE   (BOOTMODE),
    .BITWIDTH4  (BITWIDTH4),
    .BCLKIN     (BCLKIN),
    .DIN        (DIN),
    .nBSS       (nBSS),
    .nBSEN      (nBSEN),
    .nREPEN     (nREPEN),
    .nBOOTEN    (nBOOTEN),
    .nSWAPEN    (nSWAPEN),
    .BYTE       (BYTE),
    .BYTE_VALID (BYTE_VALID),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .TIMEOUT    (TIMEOUT)
  );

  // 48 MHz-class system clock.
  always #MCLK_HALF MCLK = ~MCLK;

  // Emulator CLKOUT: DIN changes on the falling edge so it is stable at each rise.
  always begin
    @(startBclk);
    bclkIdle  = 1'b0;
    edgesSent = 0;
    DIN       = sampleQ[0];
    while (edgesSent < edgeLimit) begin
      #BCLK_HALF BCLKIN = 1'b1;
      lastRise  = $time;
      edgesSent = edgesSent + 1;
      #BCLK_HALF BCLKIN = 1'b0;
      DIN = (edgesSent < sampleQ.size()) ? sampleQ[edgesSent] : 4'($urandom);
    end
    bclkIdle = 1'b1;
  end

  // Passive observer: collects bytes and pulses, and tracks strobe ordering rules.
  always @(negedge MCLK) begin
    cycle = cycle + 1;
    if (nSWAPEN !== 1'b1) swapErr = swapErr + 1;
    if (BYTE_VALID === 1'b1) begin
      gotQ.push_back(BYTE);
      lastValidCycle = cycle;
    end
    if (DONE === 1'b1) begin
      doneCnt   = doneCnt + 1;
      doneCycle = cycle;
    end
    if (TIMEOUT === 1'b1) begin
      toCnt  = toCnt + 1;
      toTime = $time;
    end
    if (prevRep && !nREPEN) begin
      repFalls    = repFalls + 1;
      repFallEdge = edgesSent;
    end
    if (prevBsen && !nBSEN) begin
      bsenFalls    = bsenFalls + 1;
      bsenFallEdge = edgesSent;
    end
    if (!nREPEN || !nBSEN) begin
      if (nBOOTEN !== ~curBoot) bootErr = bootErr + 1;
    end else if (nBOOTEN !== 1'b1) begin
      bootErr = bootErr + 1;
    end
    prevRep  = nREPEN;
    prevBsen = nBSEN;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Page model: byte b is built from its data samples, LSB first, lane0 lowest.
  function automatic logic [7:0] modelByte(input int b, input bit wide);
    int lanes = wide ? 4 : 2;
    int epb   = 8 / lanes;
    int acc   = 0;
    for (int j = 0; j < epb; j++) begin
      acc = acc + ((int'(sampleQ[PRE_EDGES + b * epb + j]) & ((1 << lanes) - 1)) << (j * lanes));
    end
    return 8'(acc);
  endfunction

  task automatic buildSamples(input int total, input int pat);
    logic [1:0] p2 [4];
    p2 = '{2'd1, 2'd2, 2'd3, 2'd0};
    sampleQ.delete();
    for (int i = 0; i < total; i++) begin
      logic [3:0] s;
      s = 4'($urandom);
      if (i >= PRE_EDGES && pat == 1) s = {s[3:2], p2[(i - PRE_EDGES) % 4]};
      if (i >= PRE_EDGES && pat == 2) s = (((i - PRE_EDGES) % 2) == 0) ? 4'hA : 4'h5;
      sampleQ.push_back(s);
    end
  endtask

  task automatic applyStimulus(input bit boot, input bit wide, input int pat, input int nBytes,
                               input int extra, input bit disturb, input string name);
    int epb   = wide ? 2 : 4;
    int total = PRE_EDGES + nBytes * epb + extra;
    bit expTo = (nBytes < PAGE);
    int baseBytes, baseDone, baseTo, baseRep, baseBsen, cyc, nGot, delay;
    buildSamples(total, pat);
    baseBytes = gotQ.size();
    baseDone  = doneCnt;
    baseTo    = toCnt;
    baseRep   = repFalls;
    baseBsen  = bsenFalls;
    curBoot   = boot;
    edgeLimit = total;
    @(negedge MCLK);
    START     = 1'b1;
    BOOTMODE  = boot;
    BITWIDTH4 = wide;
    @(negedge MCLK);
    START = 1'b0;
    checkOutput({name, ".busy"}, 32'(BUSY), 32'd1);
    #3 -> startBclk;
    #1;
    for (cyc = 0; cyc < 6000 && doneCnt == baseDone && toCnt == baseTo; cyc++) begin
      @(negedge MCLK);
      START = 1'b0;
      if (disturb && !nBSEN && (cyc % 37) == 0) begin
        START     = 1'b1;
        BITWIDTH4 = ~BITWIDTH4;
        BOOTMODE  = ~BOOTMODE;
      end
    end
    START = 1'b0;
    checkOutput({name, ".done"}, 32'(doneCnt - baseDone), expTo ? 32'd0 : 32'd1);
    checkOutput({name, ".timeout"}, 32'(toCnt - baseTo), expTo ? 32'd1 : 32'd0);
    for (cyc = 0; cyc < 2000 && !bclkIdle; cyc++) @(negedge MCLK);
    checkOutput({name, ".bclkStopped"}, 32'(bclkIdle), 32'd1);
    repeat (8) @(negedge MCLK);
    nGot = gotQ.size() - baseBytes;
    checkOutput({name, ".byteCount"}, 32'(nGot), 32'(nBytes));
    for (int b = 0; b < nBytes && b < nGot; b++) begin
      checkOutput({name, ".byte"}, 32'(gotQ[baseBytes + b]), 32'(modelByte(b, wide)));
    end
    if (pat == 1 && nGot > 0) checkOutput({name, ".byte39"}, 32'(gotQ[baseBytes]), 32'h39);
    if (pat == 2 && nGot > 0) checkOutput({name, ".byte5A"}, 32'(gotQ[baseBytes]), 32'h5A);
    checkOutput({name, ".repFalls"}, 32'(repFalls - baseRep), 32'd1);
    checkOutput({name, ".repAfterEdges"}, 32'(repFallEdge), 32'd4);
    checkOutput({name, ".bsenFalls"}, 32'(bsenFalls - baseBsen), 32'd1);
    checkOutput({name, ".bsenAfterEdges"}, 32'(bsenFallEdge), 32'(PRE_EDGES));
    if (expTo) begin
      delay = int'((toTime - lastRise) / (2 * MCLK_HALF));
      checkOutput({name, ".toDelayInWindow"}, 32'(delay >= TO_MCLK && delay <= TO_MCLK + 8), 32'd1);
    end else begin
      checkOutput({name, ".doneAfterLast"}, 32'(doneCycle - lastValidCycle), 32'd1);
    end
    checkOutput({name, ".strobesIdle"}, 32'({nBSS, nBSEN, nREPEN, nBOOTEN}), 32'hF);
    checkOutput({name, ".busyIdle"}, 32'(BUSY), 32'd0);
  endtask

  task automatic applyResetMidRead();
    int total = PRE_EDGES + PAGE * 2;
    int base, cyc;
    buildSamples(total, 0);
    base      = gotQ.size();
    curBoot   = 1'b1;
    edgeLimit = total;
    @(negedge MCLK);
    START     = 1'b1;
    BOOTMODE  = 1'b1;
    BITWIDTH4 = 1'b1;
    @(negedge MCLK);
    START = 1'b0;
    #3 -> startBclk;
    #1;
    for (cyc = 0; cyc < 3000 && gotQ.size() < base + 3; cyc++) @(negedge MCLK);
    checkOutput("rst.bytesBefore", 32'(gotQ.size() >= base + 3), 32'd1);
    checkOutput("rst.bsenBefore", 32'(nBSEN), 32'd0);
    checkOutput("rst.bootBefore", 32'(nBOOTEN), 32'd0);
    @(posedge MCLK);
    #4 nRESET = 1'b0;
    #1;
    checkOutput("rst.nBSS", 32'(nBSS), 32'd1);
    checkOutput("rst.nBSEN", 32'(nBSEN), 32'd1);
    checkOutput("rst.nBOOTEN", 32'(nBOOTEN), 32'd1);
    checkOutput("rst.busy", 32'(BUSY), 32'd0);
    edgeLimit = 0;
    for (cyc = 0; cyc < 2000 && !bclkIdle; cyc++) @(negedge MCLK);
    checkOutput("rst.bclkStopped", 32'(bclkIdle), 32'd1);
    repeat (4) @(negedge MCLK);
    nRESET = 1'b1;
    repeat (4) @(negedge MCLK);
  endtask

  initial begin
    bit rBoot, rWide;
    nRESET = 1'b0;
    repeat (3) @(negedge MCLK);
    checkOutput("reset.nBSS", 32'(nBSS), 32'd1);
    checkOutput("reset.nBSEN", 32'(nBSEN), 32'd1);
    checkOutput("reset.nREPEN", 32'(nREPEN), 32'd1);
    checkOutput("reset.nBOOTEN", 32'(nBOOTEN), 32'd1);
    checkOutput("reset.nSWAPEN", 32'(nSWAPEN), 32'd1);
    checkOutput("reset.BYTE", 32'(BYTE), 32'd0);
    checkOutput("reset.BYTE_VALID", 32'(BYTE_VALID), 32'd0);
    checkOutput("reset.BUSY", 32'(BUSY), 32'd0);
    checkOutput("reset.DONE", 32'(DONE), 32'd0);
    checkOutput("reset.TIMEOUT", 32'(TIMEOUT), 32'd0);
    nRESET = 1'b1;
    repeat (2) @(negedge MCLK);

    applyStimulus(1'b0, 1'b0, 1, PAGE, 3, 1'b0, "lane2");
    applyStimulus(1'b1, 1'b1, 2, PAGE, 3, 1'b0, "lane4boot");
    applyStimulus(1'b0, 1'b0, 0, 10, 1, 1'b0, "stall");
    rBoot = 1'($urandom);
    rWide = 1'($urandom);
    applyStimulus(rBoot, rWide, 0, PAGE, 3, 1'b1, "disturbed");
    applyResetMidRead();
    applyStimulus(1'b0, 1'b1, 0, PAGE, 2, 1'b0, "afterReset");

    checkOutput("nSWAPEN.always1", 32'(swapErr), 32'd0);
    checkOutput("nBOOTEN.rules", 32'(bootErr), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
